// File: rtl/conv_pkg.sv
// Shared widths and FIFO entry layout for the convolution output quantizer.
package conv_pkg;
    localparam int ACC_SIZE      = 21;
    localparam int OUT_WIDTH     = 8;
    localparam int OUTS_PER_CONV = 97;

    typedef struct packed {
        logic                        last;
        logic signed [OUT_WIDTH-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: entry written at edge k is presented on rd_dat after edge k.
// Backpressure: writes dropped when full, reads ignored when empty; producer flow-controls on count.
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign rd_vld = (count != '0);
    assign do_rd  = rd_rdy && rd_vld;
    assign do_wr  = wr_vld && (count != (AW+1)'(DEPTH));
    assign rd_dat = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/conv_out_quant.sv
// Requantizes convolution sums (round, arithmetic shift, saturate; optional ReLU via CONV_OUT_RELU_EN) and tags the last sample per convolution.
// Latency: sample accepted at edge k is valid on the output after edge k+1.
// Backpressure: s_ready_y from registered occupancy (fifo + pipe) only; output held while m_ready_q low.
module conv_out_quant #(
    parameter int ACC_SIZE      = conv_pkg::ACC_SIZE,
    parameter int OUT_WIDTH     = conv_pkg::OUT_WIDTH,
    parameter int SHIFT         = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int OUTS_PER_CONV = conv_pkg::OUTS_PER_CONV
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid_y,
    output logic                        s_ready_y,
    input  logic signed [ACC_SIZE-1:0]  s_data_in_y,
    output logic                        m_valid_q,
    input  logic                        m_ready_q,
    output logic signed [OUT_WIDTH-1:0] m_data_out_q,
    output logic                        m_last_q
);
    import conv_pkg::fifo_entry_t;

    localparam int CNT_W = (OUTS_PER_CONV > 1) ? $clog2(OUTS_PER_CONV) : 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(OUTS_PER_CONV - 1);
    localparam logic signed [ACC_SIZE:0] RND     = (ACC_SIZE+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_SIZE:0] SAT_MAX = (ACC_SIZE+1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_SIZE:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_SIZE:0]    x_ext;
    logic signed [ACC_SIZE:0]    rounded;
    logic signed [OUT_WIDTH-1:0] q_val;
    logic                        in_xfer;
    logic                        pipe_valid;
    logic signed [OUT_WIDTH-1:0] pipe_data;
    logic                        pipe_last;
    logic [CNT_W-1:0]            sample_cnt;
    logic [FCW-1:0]              fifo_count;
    fifo_entry_t                 wr_entry;
    fifo_entry_t                 rd_entry;

    // One extra bit of headroom so the rounding add cannot wrap.
    always_comb begin
        x_ext = {s_data_in_y[ACC_SIZE-1], s_data_in_y};
`ifdef CONV_OUT_RELU_EN
        if (s_data_in_y[ACC_SIZE-1]) x_ext = '0;
`endif
        rounded = (x_ext + RND) >>> SHIFT;
        if (rounded > SAT_MAX)      q_val = SAT_MAX[OUT_WIDTH-1:0];
        else if (rounded < SAT_MIN) q_val = SAT_MIN[OUT_WIDTH-1:0];
        else                        q_val = rounded[OUT_WIDTH-1:0];
    end

    // The pipe slot counts as occupied so a full FIFO never receives an extra write.
    assign s_ready_y = ({1'b0, fifo_count} + (FCW+1)'(pipe_valid)) < (FCW+1)'(FIFO_DEPTH);
    assign in_xfer   = s_valid_y && s_ready_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            pipe_last  <= 1'b0;
            sample_cnt <= '0;
        end else begin
            pipe_valid <= in_xfer;
            if (in_xfer) begin
                pipe_data  <= q_val;
                pipe_last  <= (sample_cnt == LAST_IDX);
                sample_cnt <= (sample_cnt == LAST_IDX) ? '0 : sample_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.last = pipe_last;
        wr_entry.data = pipe_data;
    end

    sync_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (pipe_valid),
        .wr_dat (wr_entry),
        .rd_rdy (m_ready_q),
        .rd_vld (m_valid_q),
        .rd_dat (rd_entry),
        .count  (fifo_count)
    );

    assign m_data_out_q = rd_entry.data;
    assign m_last_q     = rd_entry.last;
endmodule

// File: tb/tb_conv_out_quant.sv
// Scoreboard bench for conv_out_quant: directed quantization/latency, full/backpressure, last tagging, reset and random traffic.
module tb_conv_out_quant;
    localparam int ACC = 21;
    localparam int OW  = 8;
    localparam int SH  = 8;
    localparam int OPC = 97;
`ifdef CONV_OUT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           s_valid_y = 1'b0;
    logic           s_ready_y;
    logic [ACC-1:0] s_data_in_y = '0;
    logic           m_valid_q;
    logic           m_ready_q = 1'b0;
    logic [OW-1:0]  m_data_out_q;
    logic           m_last_q;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   idx = 0;
    int   lasts = 0;

    always #5 clk = ~clk;

    conv_out_quant dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .s_data_in_y  (s_data_in_y),
        .m_valid_q    (m_valid_q),
        .m_ready_q    (m_ready_q),
        .m_data_out_q (m_data_out_q),
        .m_last_q     (m_last_q)
    );

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: round-half-up division by 2^SH, then clamp to the output range.
    function automatic int ref_quant(int x);
        real r;
        int  v;
        if (RELU && x < 0) x = 0;
        r = $floor(($itor(x) + 2.0 ** (SH - 1)) / (2.0 ** SH));
        v = $rtoi(r);
        if (v > (2 ** (OW - 1)) - 1) v = (2 ** (OW - 1)) - 1;
        if (v < -(2 ** (OW - 1)))    v = -(2 ** (OW - 1));
        return v;
    endfunction

    function automatic logic [ACC-1:0] rand_data();
        int v;
        case ($urandom_range(0, 3))
            0:       v = $signed(ACC'($urandom));
            1:       v = int'($urandom_range(0, 4000)) - 2000;
            2:       v = int'($urandom_range(32600, 32960));
            default: v = -int'($urandom_range(32600, 32960));
        endcase
        return ACC'(v);
    endfunction

    // Monitor: inputs change only just after posedge, so the negedge view decides the next edge's transfers.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            idx = 0;
        end else begin
            if (s_valid_y && s_ready_y) begin
                q.push_back('{ref_quant($signed(s_data_in_y)), (idx == OPC - 1)});
                idx = (idx + 1) % OPC;
            end
            if (m_valid_q && m_ready_q) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_output", int'(m_valid_q), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_data", $signed(m_data_out_q), e.data);
                    check("sb_last", int'(m_last_q), int'(e.last));
                    if (m_last_q) lasts++;
                end
            end
        end
    end

    // rdy_mode: 0 hold low, 1 random, 2 always high.
    task automatic stream(int n, bit rand_valid, int rdy_mode);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 5000) begin
            @(posedge clk); #1;
            s_valid_y   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data_in_y = rand_data();
            m_ready_q   = (rdy_mode == 0) ? 1'b0 :
                          (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (s_valid_y && s_ready_y) sent++;
            guard++;
        end
        @(posedge clk); #1;
        s_valid_y = 1'b0;
        if (guard >= 5000) check("stream_timeout", sent, n);
    endtask

    task automatic drain();
        int guard = 0;
        m_ready_q = 1'b1;
        while ((q.size() != 0 || m_valid_q) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int dvals[5] = '{1000, 384, -200, 40000, -40000};
    int dexp[5]  = '{4, 2, -1, 127, (RELU ? 0 : -128)};

    initial begin
        int acc0;
        int acc;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_s_ready", int'(s_ready_y), 1);
        check("rst_m_valid", int'(m_valid_q), 0);
        check("rst_m_last", int'(m_last_q), 0);
        check("rst_m_data", $signed(m_data_out_q), 0);

        // Directed values and two-edge latency.
        m_ready_q = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s_valid_y   = 1'b1;
            s_data_in_y = ACC'(dvals[i]);
            @(posedge clk); #1;
            s_valid_y = 1'b0;
            @(negedge clk);
            check("lat_not_yet", int'(m_valid_q), 0);
            @(negedge clk);
            check("lat_valid", int'(m_valid_q), 1);
            check("dir_value", $signed(m_data_out_q), dexp[i]);
        end
        drain();

        // Backpressure: exactly FIFO_DEPTH accepted with output stalled.
        @(posedge clk); #1;
        m_ready_q = 1'b0;
        s_valid_y = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            s_data_in_y = rand_data();
            @(negedge clk);
            if (s_valid_y && s_ready_y) acc++;
            @(posedge clk); #1;
        end
        s_valid_y = 1'b0;
        @(negedge clk);
        check("full_accepted", acc, 4);
        check("full_s_ready", int'(s_ready_y), 0);
        check("full_m_valid", int'(m_valid_q), 1);
        acc0 = q.size();
        check("full_queued", acc0, 4);
        drain();
        check("resume_s_ready", int'(s_ready_y), 1);

        // Last tagging across two convolutions.
        reset_pulse();
        lasts = 0;
        stream(194, 1'b0, 1);
        drain();
        check("last_count_194", lasts, 2);

        // Reset with samples buffered.
        reset_pulse();
        stream(3, 1'b0, 0);
        repeat (2) @(negedge clk);
        check("pre_rst_m_valid", int'(m_valid_q), 1);
        reset_pulse();
        @(negedge clk);
        check("post_rst_m_valid", int'(m_valid_q), 0);
        check("post_rst_s_ready", int'(s_ready_y), 1);
        check("post_rst_m_data", $signed(m_data_out_q), 0);
        lasts = 0;
        stream(97, 1'b0, 1);
        drain();
        check("last_count_97", lasts, 1);

        // Random traffic on both sides.
        stream(300, 1'b1, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_out_quant.md
CONV_OUT_QUANT -- requirements
Module: conv_out_quant

Interface
REQ-001 Parameter ACC_SIZE, default 21, input sample width (signed).
REQ-002 Parameter OUT_WIDTH, default 8, output sample width (signed).
REQ-003 Parameter SHIFT, default 8, right-shift applied during requantization (1..ACC_SIZE-2).
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-005 Parameter OUTS_PER_CONV, default 97, samples per convolution (X_SIZE-F_SIZE+1).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 s_valid_y  input  1  upstream sample valid.
REQ-009 s_ready_y  output  1  block can accept an upstream sample.
REQ-010 s_data_in_y  input  ACC_SIZE  signed convolution sum.
REQ-011 m_valid_q  output  1  quantized sample available.
REQ-012 m_ready_q  input  1  downstream accepts sample.
REQ-013 m_data_out_q  output  OUT_WIDTH  signed quantized sample.
REQ-014 m_last_q  output  1  high with the final sample of a convolution.

Function
REQ-015 Input transfer occurs on a rising edge where s_valid_y && s_ready_y; output transfer where m_valid_q && m_ready_q.
REQ-016 Accepted samples pass through one pipeline register (pipe_valid, pipe_data, pipe_last), then are written into the FIFO on the next edge.
REQ-017 Quantization: r = (x + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_SIZE+1 bits to avoid overflow; arithmetic (floor) shift.
REQ-018 Saturation: r > 2^(OUT_WIDTH-1)-1 yields 2^(OUT_WIDTH-1)-1; r < -2^(OUT_WIDTH-1) yields -2^(OUT_WIDTH-1).
REQ-019 s_ready_y = (fifo_count + pipe_valid) < FIFO_DEPTH, derived from registered state only; no combinational path from m_ready_q.
REQ-020 Latency: sample accepted at edge k into an empty FIFO yields m_valid_q high in the cycle after edge k+1.
REQ-021 m_valid_q = (fifo_count != 0); m_data_out_q and m_last_q driven from the FIFO head entry and held stable while m_valid_q && !m_ready_q.
REQ-022 Simultaneous FIFO write and read: count unchanged, both pointers advance; read pointer and write pointer wrap modulo FIFO_DEPTH.
REQ-023 FIFO never overflows (guaranteed by REQ-019) nor underflows (read only when count != 0).
REQ-024 Sample counter 0..OUTS_PER_CONV-1 increments per input transfer; sample tagged last when counter == OUTS_PER_CONV-1; counter then wraps to 0.
REQ-025 Samples are delivered in acceptance order, none dropped or duplicated, under any m_ready_q pattern.

Reset
REQ-026 Reset held on an edge clears FIFO pointers, fifo_count, pipe_valid and sample counter, regardless of in-flight traffic.
REQ-027 In the cycle after reset: s_ready_y=1, m_valid_q=0, m_last_q=0, m_data_out_q=0.
REQ-028 Reset mid-convolution discards buffered samples; the next accepted sample is sample index 0.

Configuration
REQ-029 Macro CONV_OUT_RELU_EN defined: negative inputs are replaced by 0 before REQ-017, so outputs lie in 0..2^(OUT_WIDTH-1)-1.
REQ-030 CONV_OUT_RELU_EN undefined: no ReLU; signed range per REQ-018; latency and handshake identical in both builds.

Structure
REQ-031 Shared package conv_pkg holds ACC_SIZE, OUT_WIDTH, OUTS_PER_CONV and the FIFO entry struct {last, data}.
REQ-032 FIFO is a sub-module sync_fifo (parameterized width/depth, count output); quantize/saturate logic stays in conv_out_quant.

Verification
REQ-033 Input 1000, m_ready_q=1 -> output 4 two edges later; input 384 -> 2; input -200 -> -1 (no ReLU).
REQ-034 Input 40000 -> 127; input -40000 -> -128 without CONV_OUT_RELU_EN, 0 with it.
REQ-035 m_ready_q=0, continuous s_valid_y -> exactly 4 accepted (FIFO full with pipe drained), s_ready_y=0; release m_ready_q -> 4 samples in order, intake resumes.
REQ-036 97 back-to-back samples, random m_ready_q -> m_last_q only on the 97th output; 98th sample unflagged, 194th flagged.
REQ-037 Reset asserted with 3 samples buffered -> next cycle m_valid_q=0, s_ready_y=1; following 97 samples flag last on 97th.
